// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared types and defaults for the Viterbi decoder controller
package viterbi_pkg;

  localparam int SYM_W          = 2;
  localparam int FRAME_LEN_DEF  = 8;
  localparam int TB_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RECV,
    ST_TB_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/viterbi_if.sv
// rtl/viterbi_if.sv - symbol-pair stream from the PISO into the controller
interface viterbi_if;
  import viterbi_pkg::*;

  logic             sym_valid_i;
  logic [SYM_W-1:0] sym_data_i;
  logic             sym_ready_o;

  // Symbol producer side
  modport master (output sym_valid_i, output sym_data_i, input sym_ready_o);
  // Controller side
  modport slave  (input sym_valid_i, input sym_data_i, output sym_ready_o);

endinterface

// File: rtl/viterbi_frame_cnt.sv
// rtl/viterbi_frame_cnt.sv - symbol counter and traceback timeout counter
module viterbi_frame_cnt
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int TB_TIMEOUT = TB_TIMEOUT_DEF,
  localparam int CW = $clog2(FRAME_LEN + 1),
  localparam int AW = $clog2(FRAME_LEN),
  localparam int TW = $clog2(TB_TIMEOUT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sym_clr,
  input  logic          sym_inc,
  input  logic          tmo_clr,
  input  logic          tmo_inc,
  output logic [AW-1:0] sym_idx,
  output logic          sym_full,
  output logic          tmo_last
);

  localparam logic [CW-1:0] SYM_MAX = CW'(FRAME_LEN);
  localparam logic [TW-1:0] TMO_MAX = TW'(TB_TIMEOUT - 1);

  logic [CW-1:0] sym_cnt;
  logic [TW-1:0] tmo_cnt;

  // Symbols accepted in the current frame; clear wins over increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sym_cnt <= '0;
    end else if (sym_clr) begin
      sym_cnt <= '0;
    end else if (sym_inc) begin
      sym_cnt <= sym_cnt + 1'b1;
    end
  end

  // Cycles spent in TB_WAIT; saturates on the final cycle of the budget
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt <= '0;
    end else if (tmo_clr) begin
      tmo_cnt <= '0;
    end else if (tmo_inc && !tmo_last) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign sym_idx  = sym_cnt[AW-1:0];
  assign sym_full = (sym_cnt == SYM_MAX);
  assign tmo_last = (tmo_cnt == TMO_MAX);

endmodule

// File: rtl/viterbi_ctrl.sv
// rtl/viterbi_ctrl.sv - frame sequencer for the Viterbi BMU/ACS/traceback datapath
module viterbi_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int TB_TIMEOUT = TB_TIMEOUT_DEF,
  localparam int AW = $clog2(FRAME_LEN)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  viterbi_if.slave         sym,
  output logic [SYM_W-1:0] bm_data_o,
  output logic             pm_clr_o,
  output logic             acs_en_o,
  output logic             sv_we_o,
  output logic [AW-1:0]    sv_addr_o,
  output logic             tb_start_o,
  input  logic             tb_done_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  state_t        state;
  logic          sym_ready;
  logic          accept;
  logic          sym_clr;
  logic          tmo_clr;
  logic          tmo_inc;
  logic [AW-1:0] sym_idx;
  logic          sym_full;
  logic          tmo_last;

  assign sym_ready       = (state == ST_RECV) && !sym_full;
  assign sym.sym_ready_o = sym_ready;
  assign accept          = sym.sym_valid_i && sym_ready;

  // Counter restarts for every frame and is dropped on abort
  assign sym_clr = abort_i || (state == ST_IDLE) || (state == ST_INIT);
  assign tmo_clr = abort_i || (state != ST_TB_WAIT);
  assign tmo_inc = (state == ST_TB_WAIT);

  viterbi_frame_cnt #(
    .FRAME_LEN  (FRAME_LEN),
    .TB_TIMEOUT (TB_TIMEOUT)
  ) u_frame_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sym_clr  (sym_clr),
    .sym_inc  (accept),
    .tmo_clr  (tmo_clr),
    .tmo_inc  (tmo_inc),
    .sym_idx  (sym_idx),
    .sym_full (sym_full),
    .tmo_last (tmo_last)
  );

  // Frame sequencer with registered datapath strobes; abort overrides everything
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      bm_data_o  <= '0;
      sv_addr_o  <= '0;
      acs_en_o   <= 1'b0;
      tb_start_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      acs_en_o   <= 1'b0;
      tb_start_o <= 1'b0;
      if (abort_i) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i) begin
              state <= ST_INIT;
              err_o <= 1'b0;
            end
          end
          ST_INIT: begin
            state <= ST_RECV;
          end
          ST_RECV: begin
            if (accept) begin
              bm_data_o <= sym.sym_data_i;
              sv_addr_o <= sym_idx;
              acs_en_o  <= 1'b1;
            end
            // Leave once the last symbol's ACS update is on the wire
            if (acs_en_o && sym_full) begin
              state      <= ST_TB_WAIT;
              tb_start_o <= 1'b1;
            end
          end
          ST_TB_WAIT: begin
            // A done seen alongside the start strobe belongs to a stale traceback
            if (tb_done_i && !tb_start_o) begin
              state <= ST_DONE;
            end else if (tmo_last) begin
              state <= ST_IDLE;
              err_o <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign pm_clr_o = (state == ST_INIT);
  assign busy_o   = (state != ST_IDLE);
  assign done_o   = (state == ST_DONE);
  assign sv_we_o  = acs_en_o;

endmodule

// File: tb/tb_viterbi_ctrl.sv
// tb/tb_viterbi_ctrl.sv - directed self-checking bench for viterbi_ctrl
module tb_viterbi_ctrl;
  import viterbi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       tb_done = 1'b0;
  logic [1:0] bm_data;
  logic [2:0] sv_addr;
  logic       pm_clr, acs_en, sv_we, tb_start, busy, done, err;

  int tests = 0;
  int fails = 0;
  int n_pm, n_acs, n_we, n_tbs, n_done, exp_addr;
  logic bad;

  logic [1:0] pat [8] = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01};

  viterbi_if sym_bus ();

  viterbi_ctrl #(.FRAME_LEN(8), .TB_TIMEOUT(64)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .abort_i    (abort),
    .sym        (sym_bus),
    .bm_data_o  (bm_data),
    .pm_clr_o   (pm_clr),
    .acs_en_o   (acs_en),
    .sv_we_o    (sv_we),
    .sv_addr_o  (sv_addr),
    .tb_start_o (tb_start),
    .tb_done_i  (tb_done),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pm_clr)   n_pm++;
    if (sv_we)    n_we++;
    if (tb_start) n_tbs++;
    if (done)     n_done++;
    if (acs_en) begin
      n_acs++;
      check("sv_addr", {29'd0, sv_addr}, exp_addr);
      exp_addr++;
    end
  endtask

  task automatic clear_counts();
    n_pm = 0; n_acs = 0; n_we = 0; n_tbs = 0; n_done = 0; exp_addr = 0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      sym_bus.sym_valid_i = 1'b1;
      sym_bus.sym_data_i  = pat[i % 8];
      tick();
      check("bm_data", {30'd0, bm_data}, {30'd0, pat[i % 8]});
    end
    sym_bus.sym_valid_i = 1'b0;
  endtask

  initial begin
    sym_bus.sym_valid_i = 1'b0;
    sym_bus.sym_data_i  = 2'b00;
    clear_counts();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy, sym_bus.sym_ready_o, pm_clr, acs_en, sv_we, tb_start, done, err, bm_data, sv_addr}, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // nominal frame
    clear_counts();
    start = 1'b1;
    tick();
    check("init_pm_clr", pm_clr, 1);
    check("init_busy", busy, 1);
    start = 1'b0;
    tick();
    check("recv_ready", sym_bus.sym_ready_o, 1);
    check("recv_pm_clr", pm_clr, 0);
    feed(8);
    check("ready_after_8", sym_bus.sym_ready_o, 0);
    tick();
    check("tb_start", tb_start, 1);
    tick();
    check("tb_start_one_cycle", tb_start, 0);
    tick();
    tick();
    tb_done = 1'b1;
    tick();
    check("nom_done", done, 1);
    tb_done = 1'b0;
    tick();
    check("nom_done_drop", done, 0);
    check("nom_idle", busy, 0);
    check("nom_pm_cnt", n_pm, 1);
    check("nom_acs_cnt", n_acs, 8);
    check("nom_we_cnt", n_we, 8);
    check("nom_tbs_cnt", n_tbs, 1);
    check("nom_done_cnt", n_done, 1);

    // gapped input
    clear_counts();
    start_frame();
    for (int i = 0; i < 20; i++) begin
      sym_bus.sym_valid_i = ((i % 2) == 0);
      sym_bus.sym_data_i  = pat[(i / 2) % 8];
      tick();
    end
    sym_bus.sym_valid_i = 1'b0;
    check("gap_acs_cnt", n_acs, 8);
    check("gap_ready_low", sym_bus.sym_ready_o, 0);
    check("gap_tbs_cnt", n_tbs, 1);
    tb_done = 1'b1;
    tick();
    check("gap_done", done, 1);
    tb_done = 1'b0;
    tick();
    check("gap_idle", busy, 0);

    // traceback timeout
    clear_counts();
    start_frame();
    feed(8);
    tick();
    check("tmo_tb_start", tb_start, 1);
    bad = 1'b0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (err || !busy) bad = 1'b1;
    end
    check("tmo_wait_63", bad, 0);
    tick();
    check("tmo_err", err, 1);
    check("tmo_idle", busy, 0);
    check("tmo_no_done", n_done, 0);
    tick();
    check("tmo_err_sticky", err, 1);
    start = 1'b1;
    tick();
    check("tmo_err_cleared", err, 0);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_from_init", busy, 0);

    // abort on the 5th accept
    clear_counts();
    start_frame();
    feed(4);
    sym_bus.sym_valid_i = 1'b1;
    sym_bus.sym_data_i  = pat[4];
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sym_bus.sym_valid_i = 1'b0;
    check("abort_no_acs", acs_en, 0);
    check("abort_idle", busy, 0);
    check("abort_ready", sym_bus.sym_ready_o, 0);
    check("abort_cnt", dut.u_frame_cnt.sym_cnt, 0);
    tick();
    check("abort_acs_cnt", n_acs, 4);

    // asynchronous reset mid-RECV
    clear_counts();
    start_frame();
    feed(3);
    check("pre_rst_acs", acs_en, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", {busy, sym_bus.sym_ready_o, pm_clr, acs_en, sv_we, tb_start, done, err, bm_data, sv_addr}, 0);
    check("async_rst_cnt", dut.u_frame_cnt.sym_cnt, 0);
    #2 rst = 1'b0;
    tick();
    check("post_rst_idle", busy, 0);
    clear_counts();
    start_frame();
    feed(8);
    tick();
    check("post_rst_tb_start", tb_start, 1);
    tick();
    tb_done = 1'b1;
    tick();
    check("post_rst_done", done, 1);
    tb_done = 1'b0;
    tick();
    check("post_rst_acs_cnt", n_acs, 8);
    check("post_rst_done_cnt", n_done, 1);

    // start held high, early tb_done in the tb_start cycle
    clear_counts();
    start = 1'b1;
    tick();
    tick();
    feed(8);
    tick();
    check("held_tb_start", tb_start, 1);
    tb_done = 1'b1;
    tick();
    check("early_done_ignored", done, 0);
    check("early_done_busy", busy, 1);
    tb_done = 1'b0;
    tick();
    tb_done = 1'b1;
    tick();
    check("held_done", done, 1);
    start = 1'b0;
    tb_done = 1'b0;
    tick();
    check("held_pm_cnt", n_pm, 1);
    check("held_acs_cnt", n_acs, 8);
    check("held_idle", busy, 0);
    check("held_no_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/viterbi_ctrl.md
VITERBI_CTRL -- requirements
Module: viterbi_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 8: symbol pairs per frame; legal range 2..256.
REQ-002 Parameter TB_TIMEOUT, default 64: maximum cycles spent waiting for tb_done_i.
REQ-003 Localparam CW = clog2(FRAME_LEN+1): symbol counter width; AW = clog2(FRAME_LEN): address width.
REQ-004 Port clk_i, input, 1: single clock; all logic on rising edge.
REQ-005 Port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 Port start_i, input, 1: begin frame; honoured only in IDLE.
REQ-007 Port abort_i, input, 1: synchronous abort; returns the block to IDLE from any state.
REQ-008 Port sym_valid_i, input, 1: symbol pair valid from PISO.
REQ-009 Port sym_data_i, input, 2: received symbol pair.
REQ-010 Port sym_ready_o, output, 1: controller accepts a symbol.
REQ-011 Port bm_data_o, output, 2: registered symbol driven to the BMU.
REQ-012 Port pm_clr_o, output, 1: one-cycle path-metric init strobe (state 0 = 0, other states = max).
REQ-013 Port acs_en_o, output, 1: one-cycle ACS/path-metric update strobe.
REQ-014 Port sv_we_o, output, 1: survivor-memory write enable; equals acs_en_o.
REQ-015 Port sv_addr_o, output, AW: survivor-memory write address.
REQ-016 Port tb_start_o, output, 1: one-cycle traceback start strobe.
REQ-017 Port tb_done_i, input, 1: traceback complete.
REQ-018 Port busy_o, output, 1: high in every state except IDLE.
REQ-019 Port done_o, output, 1: one-cycle frame-complete pulse.
REQ-020 Port err_o, output, 1: sticky traceback-timeout flag.

Function
REQ-021 The FSM SHALL have states IDLE, INIT, RECV, TB_WAIT and DONE.
REQ-022 IDLE -> INIT on start_i; pm_clr_o SHALL be high for exactly the INIT cycle; INIT -> RECV unconditionally.
REQ-023 In RECV, sym_ready_o SHALL equal (cnt < FRAME_LEN); it is low in all other states.
REQ-024 On sym_valid_i & sym_ready_o: bm_data_o <= sym_data_i, and cnt increments.
REQ-025 acs_en_o and sv_we_o SHALL pulse the cycle after each accept, with sv_addr_o = index of that symbol (0..FRAME_LEN-1): latency 1.
REQ-026 When the FRAME_LEN-th accept's acs_en_o fires, the FSM SHALL go to TB_WAIT; tb_start_o SHALL pulse in the first TB_WAIT cycle.
REQ-027 tb_done_i SHALL be ignored in the tb_start_o cycle and outside TB_WAIT.
REQ-028 tb_done_i in TB_WAIT -> DONE; done_o SHALL be high for the DONE cycle, then the FSM returns to IDLE.
REQ-029 If TB_TIMEOUT cycles elapse in TB_WAIT without tb_done_i, err_o SHALL set, the FSM SHALL go to IDLE, and no done_o SHALL pulse.
REQ-030 err_o SHALL clear only on reset or on an accepted start_i.
REQ-031 start_i outside IDLE SHALL be ignored.
REQ-032 abort_i has the highest priority: it clears cnt; it suppresses a pending acs_en_o, tb_start_o and done_o in the same cycle; next state is IDLE.
REQ-033 sym_valid_i without sym_ready_o SHALL cause no counter change, strobe or bm_data_o update.

Reset
REQ-034 On rst_i: state = IDLE; cnt = 0; bm_data_o = 0; sv_addr_o = 0; err_o = 0; all strobes, sym_ready_o and busy_o = 0.
REQ-035 Reset mid-frame SHALL discard the frame; outputs reach their reset values immediately (asynchronously).

Structure
REQ-036 Shared package viterbi_pkg SHALL hold the state enum, the FRAME_LEN/TB_TIMEOUT defaults and the symbol width constant (2).
REQ-037 One sub-module, viterbi_frame_cnt, SHALL hold the symbol counter and the timeout counter; the FSM stays in viterbi_ctrl.

Verification
REQ-038 Nominal frame: FRAME_LEN=8, start, 8 back-to-back symbols 00,11,10,01,00,11,10,01, tb_done_i 3 cycles after tb_start_o -> pm_clr_o pulses once; 8 acs_en_o pulses with sv_addr_o 0..7; done_o pulses once.
REQ-039 Gapped input: sym_valid_i toggling every other cycle -> exactly 8 accepts; sym_ready_o low after the 8th.
REQ-040 Timeout: tb_done_i never asserted -> err_o high after 64 TB_WAIT cycles; no done_o; next start_i clears err_o.
REQ-041 Abort on the cycle the 5th symbol is accepted -> no acs_en_o for it; IDLE next cycle; cnt = 0.
REQ-042 Asynchronous rst_i mid-RECV (cnt=3) -> all outputs at reset values before the next clock edge; a new frame completes normally.
REQ-043 start_i held high through a frame plus an early tb_done_i in the tb_start_o cycle -> no restart; the early tb_done_i is ignored.
